// File: rtl/eth_tx_frame_buffer.sv
// Store-and-forward Ethernet TX frame buffer: frames are released to the MAC only
// once fully stored; aborted or oversized frames are discarded whole and counted.
module eth_tx_frame_buffer #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] drop_count,
  output logic        drop_pulse
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int PTR_W  = ADDR_WIDTH + 1;
  localparam int WORD_W = 73;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

  typedef enum logic {IDLE_OR_FRAME, DROP} wr_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [WORD_W-1:0] mem [DEPTH];

  wr_state_t        state, state_d;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_d;
  logic [PTR_W-1:0] wr_commit, wr_commit_d;
  logic [PTR_W-1:0] wr_commit_rd;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] used;
  logic             bad, bad_d;
  logic             beat, full, wr_en, drop;

  logic              rd_en, pop;
  logic [1:0]        occ;
  logic [WORD_W-1:0] rd_word_p1;
  logic              vld_p1;
  logic [WORD_W-1:0] head_word_p2, skid_word_p2;
  logic              head_vld_p2, skid_vld_p2;

  assign s_axis_tready = ~reset;
  assign beat = s_axis_tvalid & s_axis_tready;
  assign used = wr_ptr - rd_ptr;
  assign full = (used == PTR_FULL);

  always_comb begin
    state_d     = state;
    wr_en       = 1'b0;
    wr_ptr_d    = wr_ptr;
    wr_commit_d = wr_commit;
    bad_d       = bad;
    drop        = 1'b0;
    if (beat) begin
      case (state)
        IDLE_OR_FRAME: begin
          if (!full) begin
            wr_en = 1'b1;
            if (!s_axis_tlast) begin
              wr_ptr_d = wr_ptr + PTR_ONE;
              bad_d    = bad | s_axis_tuser;
            end else if (bad | s_axis_tuser) begin
              wr_ptr_d = wr_commit;
              drop     = 1'b1;
              bad_d    = 1'b0;
            end else begin
              wr_ptr_d    = wr_ptr + PTR_ONE;
              wr_commit_d = wr_ptr + PTR_ONE;
              bad_d       = 1'b0;
            end
          end else if (s_axis_tlast) begin
            wr_ptr_d = wr_commit;
            drop     = 1'b1;
            bad_d    = 1'b0;
          end else begin
            state_d = DROP;
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            wr_ptr_d = wr_commit;
            drop     = 1'b1;
            bad_d    = 1'b0;
            state_d  = IDLE_OR_FRAME;
          end
        end
        default: state_d = IDLE_OR_FRAME;
      endcase
    end
  end

  // The read side sees commits one cycle late so rollback never races a read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE_OR_FRAME;
      wr_ptr       <= '0;
      wr_commit    <= '0;
      wr_commit_rd <= '0;
      bad          <= 1'b0;
      drop_pulse   <= 1'b0;
      drop_count   <= '0;
    end else begin
      state        <= state_d;
      wr_ptr       <= wr_ptr_d;
      wr_commit    <= wr_commit_d;
      wr_commit_rd <= wr_commit;
      bad          <= bad_d;
      drop_pulse   <= drop;
      if (drop) drop_count <= sat_inc16(drop_count);
    end
  end

  // Stage p1: registered RAM read
  assign pop   = head_vld_p2 & m_axis_tready;
  assign occ   = {1'b0, head_vld_p2} + {1'b0, skid_vld_p2} + {1'b0, vld_p1};
  assign rd_en = (rd_ptr != wr_commit_rd) && ((occ <= 2'd1) || ((occ == 2'd2) && pop));

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (rd_en) rd_word_p1 <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  // Stage p2: two-entry skid buffer; the head drives m_axis directly
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      vld_p1       <= 1'b0;
      head_vld_p2  <= 1'b0;
      skid_vld_p2  <= 1'b0;
      head_word_p2 <= '0;
      skid_word_p2 <= '0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (!head_vld_p2 || pop) begin
        if (skid_vld_p2) begin
          head_word_p2 <= skid_word_p2;
          head_vld_p2  <= 1'b1;
          if (vld_p1) skid_word_p2 <= rd_word_p1;
          else        skid_vld_p2  <= 1'b0;
        end else begin
          head_vld_p2 <= vld_p1;
          if (vld_p1) head_word_p2 <= rd_word_p1;
        end
      end else if (vld_p1) begin
        skid_word_p2 <= rd_word_p1;
        skid_vld_p2  <= 1'b1;
      end
    end
  end

  assign m_axis_tdata  = head_word_p2[63:0];
  assign m_axis_tkeep  = head_word_p2[71:64];
  assign m_axis_tlast  = head_word_p2[72];
  assign m_axis_tuser  = 1'b0;
  assign m_axis_tvalid = head_vld_p2;

endmodule
